multiplexador_display: RTL and testbench

MULTIPLEXADOR_DISPLAY -- requirements
Module: multiplexador_display

---
 rtl/multiplexador_display.sv | 112 +++++++++++
 tb/tb_multiplexador_display.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplexador_display.sv
// multiplexador_display
//   Time-multiplexed driver for a four-digit 7-segment display. A prescaler
//   divides clk down to one digit slot every DIV cycles. A 2-bit index walks
//   digits 0..3, and the display shows one digit per slot. New values are
//   double-buffered: a load lands in a pending buffer. The pending buffer is
//   copied to the active buffer only at the frame boundary (index 3 -> 0),
//   so a frame never mixes old and new digits.
//
//   Optional feature: define MULTIPLEXADOR_DISPLAY_LZB_EN to enable
//   leading-zero blanking. Digits 3..1 show 4'hF (blank) while they and all
//   higher digits are zero. Digit 0 is never blanked.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   load      capture value into the pending buffer
//   value     four BCD nibbles, value[3:0] is digit 0 (rightmost)
//   sel       nibble code for the downstream 7-segment decoder
//   digit_en  active-low digit enables, bit n enables digit n
//   upd       one-cycle pulse, high in the first cycle of a frame whose
//             data was just transferred from pending to active
module multiplexador_display #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  sel,
  output logic [3:0]  digit_en,
  output logic        upd
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pending_valid;

  logic          wrap;
  logic          transfer;
  logic [3:0]    nibble;

  assign wrap     = (presc == LAST);
  // The transfer happens on the edge that takes the index from 3 back to 0.
  // The new frame therefore starts on fresh data at digit 0.
  assign transfer = wrap && (idx == 2'd3) && pending_valid;

  // NOTE: every register here is assigned with <=, so all of them see the
  // pre-edge values. This lets a coincident load and transfer move the old
  // pending data while the new value becomes pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc         <= '0;
      idx           <= 2'd0;
      active        <= 16'hFFFF;
      pending       <= 16'hFFFF;
      pending_valid <= 1'b0;
      upd           <= 1'b0;
    end else begin
      upd <= transfer;

      if (wrap) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + CW'(1);
      end

      if (transfer) begin
        active <= pending;
      end

      // A load always wins over the clear. Several loads within one frame
      // simply overwrite pending, which gives last-wins behaviour.
      if (load) begin
        pending       <= value;
        pending_valid <= 1'b1;
      end else if (transfer) begin
        pending_valid <= 1'b0;
      end
    end
  end

  assign digit_en = ~(4'b0001 << idx);
  assign nibble   = active[{idx, 2'b00} +: 4];

`ifdef MULTIPLEXADOR_DISPLAY_LZB_EN
  logic lead_zero;

  // NOTE: lead_zero gets a default before the case statement, so no path
  // through this block leaves it unassigned and no latch is inferred.
  always_comb begin
    lead_zero = 1'b0;
    case (idx)
      2'd3:    lead_zero = (active[15:12] == 4'h0);
      2'd2:    lead_zero = (active[15:8]  == 8'h00);
      2'd1:    lead_zero = (active[15:4]  == 12'h000);
      default: lead_zero = 1'b0;
    endcase
  end

  assign sel = lead_zero ? 4'hF : nibble;
`else
  // Codes 10..15 pass through unchanged; the decoder blanks them itself.
  assign sel = nibble;
`endif

endmodule

// File: tb/tb_multiplexador_display.sv
// tb_multiplexador_display
//   Bench for multiplexador_display with DIV=4. A frame is 16 cycles, and
//   each digit slot lasts 4 cycles. A reference model tracks the cycles
//   since reset, plus the active and pending data. The displayed digit is
//   derived arithmetically from that cycle count. The compare process checks
//   sel, digit_en and upd against the model on every falling edge. Directed
//   scenarios add literal expectations computed by hand.
`timescale 1ns/1ps
module tb_multiplexador_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  sel;
  logic [3:0]  digit_en;
  logic        upd;

  int checks   = 0;
  int failures = 0;
  int upd_seen = 0;

  multiplexador_display #(.DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .sel      (sel),
    .digit_en (digit_en),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. m_t counts the clock cycles since reset was released,
  // so the frame position is simply m_t % 16.
  int          m_t     = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_act   = 16'hFFFF;
  logic [15:0] m_pend  = 16'hFFFF;
  bit          m_pv    = 1'b0;
  bit          m_upd   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t     = 0;
      m_valid = 1'b1;
      m_act   = 16'hFFFF;
      m_pend  = 16'hFFFF;
      m_pv    = 1'b0;
      m_upd   = 1'b0;
    end else begin
      m_upd = ((m_t % 16) == 15) && m_pv;
      if (m_upd) m_act = m_pend;
      if (load) begin
        m_pend = value;
        m_pv   = 1'b1;
      end else if (m_upd) begin
        m_pv = 1'b0;
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int d;
      logic [3:0]  exp_en;
      logic [15:0] upper;
      logic [3:0]  exp_sel;
      d       = (m_t / 4) % 4;
      exp_en  = 4'b1111;
      exp_en[d] = 1'b0;
      upper   = m_act >> (4 * d);
      exp_sel = upper[3:0];
`ifdef MULTIPLEXADOR_DISPLAY_LZB_EN
      if (d != 0 && upper == 16'h0000) exp_sel = 4'hF;
`endif
      check("model_sel", sel, exp_sel);
      check("model_digit_en", digit_en, exp_en);
      check("model_upd", upd, m_upd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (upd === 1'b1) upd_seen++;
  endtask

  task automatic goto(input int target);
    int n = 0;
    while (m_t != target && n < 300) begin
      step();
      n++;
    end
    if (m_t != target) check("goto_timeout", m_t, target);
  endtask

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
  endtask

  localparam bit LZB =
`ifdef MULTIPLEXADOR_DISPLAY_LZB_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    // Reset: the first cycle after reset shows digit 0 of 16'hFFFF.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_sel", sel, 4'hF);
    check("reset_en", digit_en, 4'b1110);
    check("reset_upd", upd, 1'b0);
    upd_seen = 0;
    goto(4);  check("step_en1", digit_en, 4'b1101);
    goto(8);  check("step_en2", digit_en, 4'b1011);
    goto(12); check("step_en3", digit_en, 4'b0111);
    goto(16); check("step_en0", digit_en, 4'b1110);
    check("reset_no_upd", upd_seen, 0);

    // Single load during index 1; active must stay FFFF until the wrap.
    goto(20);
    do_load(16'h1234);
    check("load_no_early", sel, 4'hF);
    goto(32);
    check("load_upd", upd, 1'b1);
    check("load_d0", sel, 4'h4);
    goto(36); check("load_d1", sel, 4'h3);
    goto(40); check("load_d2", sel, 4'h2);
    goto(44); check("load_d3", sel, 4'h1);
    check("load_one_upd", upd_seen, 1);

    // Last-wins: two loads in one frame produce a single transfer.
    goto(48);
    upd_seen = 0;
    do_load(16'h1111);
    goto(52);
    do_load(16'h2222);
    goto(64);
    check("lw_upd", upd, 1'b1);
    check("lw_d0", sel, 4'h2);
    goto(76); check("lw_d3", sel, 4'h2);
    goto(80);
    check("lw_one_upd", upd_seen, 1);

    // Coincident load: 5678 arrives on the wrap edge while 1234 is pending.
    upd_seen = 0;
    goto(81);
    do_load(16'h1234);
    goto(95);
    do_load(16'h5678);
    check("co_upd1", upd, 1'b1);
    check("co_d0a", sel, 4'h4);
    goto(108); check("co_d3a", sel, 4'h1);
    goto(112);
    check("co_upd2", upd, 1'b1);
    check("co_d0b", sel, 4'h8);
    goto(124); check("co_d3b", sel, 4'h5);
    check("co_two_upd", upd_seen, 2);

    // Leading-zero blanking (or raw nibbles without it).
    do_load(16'h0045);
    goto(128); check("lz_d0", sel, 4'h5);
    goto(132); check("lz_d1", sel, 4'h4);
    goto(136); check("lz_d2", sel, LZB ? 4'hF : 4'h0);
    goto(140); check("lz_d3", sel, LZB ? 4'hF : 4'h0);
    goto(144);
    do_load(16'h0000);
    goto(160); check("z_d0", sel, 4'h0);
    goto(164); check("z_d1", sel, LZB ? 4'hF : 4'h0);
    goto(172); check("z_d3", sel, LZB ? 4'hF : 4'h0);

    // Reset mid-frame at index 2 with a load pending: pending is discarded.
    goto(176);
    do_load(16'h9999);
    goto(184);
    check("mid_idx2", digit_en, 4'b1011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_sel", sel, 4'hF);
    check("mid_en", digit_en, 4'b1110);
    check("mid_upd", upd, 1'b0);
    upd_seen = 0;
    goto(40);
    check("mid_no_upd", upd_seen, 0);
    check("mid_no_show", sel, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
